// File: rtl/spio_wrr_pkg.sv
// Shared constants and types for the four-input weighted round-robin arbiter.
package spio_wrr_pkg;

  localparam int NUM_PORTS       = 4;
  localparam int PORT_BITS       = 2;
  localparam int DEF_WEIGHT_BITS = 4;

  typedef logic [PORT_BITS-1:0]       port_t;
  typedef logic [DEF_WEIGHT_BITS-1:0] weight_t;

  // Pointer and burst counter restart at input 0 with no burst credit used.
  localparam port_t   PTR_RST = '0;
  localparam weight_t CNT_RST = '0;

  // Next input index in cyclic order; the 2-bit wrap gives mod-4 for free.
  function automatic port_t port_inc(input port_t p);
    return p + port_t'(1);
  endfunction

endpackage

// File: rtl/spio_wrr_grant.sv
// Cyclic first-eligible search: rotate the request vector so ptr sits at
// bit 0, pick the lowest set bit, then rotate the index back.
module spio_wrr_grant
  import spio_wrr_pkg::*;
(
  input  logic [NUM_PORTS-1:0] elig_i,
  input  port_t                ptr_i,
  output logic                 grant_valid_o,
  output port_t                grant_o
);

  logic [NUM_PORTS-1:0] rot;
  port_t                off;
  logic                 found;

  // Rotate, priority-encode from the pointer position, and unrotate.
  always_comb begin
    rot   = '0;
    off   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      rot[i] = elig_i[port_t'(i) + ptr_i];
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && rot[i]) begin
        off   = port_t'(i);
        found = 1'b1;
      end
    end
    grant_valid_o = found;
    grant_o       = off + ptr_i;
  end

endmodule

// File: rtl/spio_wrr_arbiter4.sv
// Four-input weighted round-robin arbiter feeding one registered output
// stream tagged with the source index. Each input may send up to WEIGHTn
// consecutive packets before the grant rotates; weight 0 masks the input.
//
// Handshake: on every stream a packet moves on the rising edge where both
// valid and ready are high. Valid never depends on ready; the upstream
// RDYn_OUT depends combinationally on RDY_IN through the load enable.
module spio_wrr_arbiter4
  import spio_wrr_pkg::*;
#(
  parameter int PKT_BITS    = 72,
  parameter int WEIGHT_BITS = 4
) (
  input  logic                   CLK_IN,
  input  logic                   RESET_IN,
  input  logic [PKT_BITS-1:0]    DATA0_IN,
  input  logic [PKT_BITS-1:0]    DATA1_IN,
  input  logic [PKT_BITS-1:0]    DATA2_IN,
  input  logic [PKT_BITS-1:0]    DATA3_IN,
  input  logic                   VLD0_IN,
  input  logic                   VLD1_IN,
  input  logic                   VLD2_IN,
  input  logic                   VLD3_IN,
  output logic                   RDY0_OUT,
  output logic                   RDY1_OUT,
  output logic                   RDY2_OUT,
  output logic                   RDY3_OUT,
  input  logic [WEIGHT_BITS-1:0] WEIGHT0_IN,
  input  logic [WEIGHT_BITS-1:0] WEIGHT1_IN,
  input  logic [WEIGHT_BITS-1:0] WEIGHT2_IN,
  input  logic [WEIGHT_BITS-1:0] WEIGHT3_IN,
  output logic [PKT_BITS-1:0]    DATA_OUT,
  output logic [PORT_BITS-1:0]   SRC_OUT,
  output logic                   VLD_OUT,
  input  logic                   RDY_IN
);

  logic [PKT_BITS-1:0]    data_in   [NUM_PORTS];
  logic [WEIGHT_BITS-1:0] weight_in [NUM_PORTS];
  logic [NUM_PORTS-1:0]   vld_in;
  logic [NUM_PORTS-1:0]   elig;
  logic [NUM_PORTS-1:0]   rdy_vec;

  logic                   grant_valid;
  port_t                  grant;
  logic                   ld;
  logic                   xfer;
  logic [WEIGHT_BITS:0]   cnt_base;
  logic [WEIGHT_BITS:0]   new_cnt;

  logic [PKT_BITS-1:0]    data_q, data_d;
  port_t                  src_q, src_d;
  logic                   vld_q, vld_d;
  port_t                  ptr_q, ptr_d;
  logic [WEIGHT_BITS-1:0] cnt_q, cnt_d;

  assign data_in[0]   = DATA0_IN;
  assign data_in[1]   = DATA1_IN;
  assign data_in[2]   = DATA2_IN;
  assign data_in[3]   = DATA3_IN;
  assign weight_in[0] = WEIGHT0_IN;
  assign weight_in[1] = WEIGHT1_IN;
  assign weight_in[2] = WEIGHT2_IN;
  assign weight_in[3] = WEIGHT3_IN;
  assign vld_in       = {VLD3_IN, VLD2_IN, VLD1_IN, VLD0_IN};

  // An input competes only when it has a packet and a non-zero weight.
  always_comb begin
    elig = '0;
    for (int n = 0; n < NUM_PORTS; n++) begin
      elig[n] = vld_in[n] & (weight_in[n] != '0);
    end
  end

  spio_wrr_grant u_grant (
    .elig_i        (elig),
    .ptr_i         (ptr_q),
    .grant_valid_o (grant_valid),
    .grant_o       (grant)
  );

  // The output register can take a packet when empty or being drained.
  assign ld   = ~vld_q | RDY_IN;
  assign xfer = ld & grant_valid & ~RESET_IN;

  // One-hot ready to the granted input; reset silences all handshakes.
  always_comb begin
    rdy_vec = '0;
    if (xfer) begin
      rdy_vec[grant] = 1'b1;
    end
  end

  assign RDY0_OUT = rdy_vec[0];
  assign RDY1_OUT = rdy_vec[1];
  assign RDY2_OUT = rdy_vec[2];
  assign RDY3_OUT = rdy_vec[3];

  // Burst length so far including this transfer; a grant to a different
  // input than the pointer starts a fresh burst, so credit is never kept.
  always_comb begin
    cnt_base = (grant == ptr_q) ? {1'b0, cnt_q} : '0;
    new_cnt  = cnt_base + (WEIGHT_BITS+1)'(1);
  end

  // Next-state for the output register and the pointer/burst counter.
  always_comb begin
    data_d = data_q;
    src_d  = src_q;
    vld_d  = vld_q;
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    if (xfer) begin
      data_d = data_in[grant];
      src_d  = grant;
      vld_d  = 1'b1;
      if (new_cnt >= {1'b0, weight_in[grant]}) begin
        ptr_d = port_inc(grant);
        cnt_d = '0;
      end else begin
        ptr_d = grant;
        cnt_d = new_cnt[WEIGHT_BITS-1:0];
      end
    end else if (vld_q & RDY_IN) begin
      vld_d = 1'b0;
    end
  end

  // State registers with synchronous reset; a held packet is dropped.
  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      data_q <= '0;
      src_q  <= '0;
      vld_q  <= 1'b0;
      ptr_q  <= PTR_RST;
      cnt_q  <= WEIGHT_BITS'(CNT_RST);
    end else begin
      data_q <= data_d;
      src_q  <= src_d;
      vld_q  <= vld_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign DATA_OUT = data_q;
  assign SRC_OUT  = src_q;
  assign VLD_OUT  = vld_q;

endmodule

// File: doc/spio_wrr_arbiter4.md
Name: spio_wrr_arbiter4

Overview:
- Four-input weighted round-robin arbiter for SpiNNaker I/O packet streams, all using valid/ready handshakes.
- Each input gets bursts of up to WEIGHTn consecutive packets before the grant rotates, so link streams can be given bandwidth shares.
- Feeds one registered output stream, tagged with the source port.
- Sits where the 2-input round-robin arbiter sits, for example merging several link receivers into one router/switch input.

Parameters:
- PKT_BITS, 72, packet width in bits.
- WEIGHT_BITS, 4, width of each weight and of the burst counter.

Ports:
- CLK_IN  in  1  system clock.
- RESET_IN  in  1  reset; synchronous, active-high.
- DATAn_IN (n=0..3)  in  PKT_BITS  input packet n.
- VLDn_IN (n=0..3)  in  1  input n valid.
- RDYn_OUT (n=0..3)  out  1  input n ready.
- WEIGHTn_IN (n=0..3)  in  WEIGHT_BITS  burst length for input n; 0 = input masked (never granted).
- DATA_OUT  out  PKT_BITS  output packet (registered).
- SRC_OUT  out  2  index of the input that DATA_OUT came from (registered with DATA_OUT).
- VLD_OUT  out  1  output valid (registered).
- RDY_IN  in  1  downstream ready.

Behaviour:
- Single clock; all state is updated on the rising edge of CLK_IN; RESET_IN is sampled synchronously.
- Reset values: VLD_OUT=0, DATA_OUT=0, SRC_OUT=0, pointer ptr=0, burst counter cnt=0.
- While RESET_IN=1, all RDYn_OUT=0 (combinationally forced).
- Eligibility: input n is eligible when VLDn_IN=1 and WEIGHTn_IN!=0.
- Grant g is combinational: the first eligible input found searching cyclically from ptr (ptr, ptr+1, ... mod 4). No eligible input means no grant.
- Load enable: ld = ~VLD_OUT | RDY_IN.
- Ready: RDYn_OUT = ld & grant_valid & (g==n) & ~RESET_IN. At most one RDY is high in any cycle. RDY_IN→RDYn_OUT is a combinational path.
- Transfer from input g occurs when VLDg_IN & RDYg_OUT. On the next edge:
  - DATA_OUT<=DATAg_IN, SRC_OUT<=g, VLD_OUT<=1.
  - Compute new=(g==ptr ? cnt : 0)+1.
  - If new >= WEIGHTg_IN: ptr<=g+1 (mod 4), cnt<=0. Otherwise: ptr<=g, cnt<=new.
- Output consumed with no new transfer (VLD_OUT & RDY_IN, no grant): VLD_OUT<=0; DATA_OUT and SRC_OUT hold.
- Stall (VLD_OUT=1, RDY_IN=0): no RDY is asserted; DATA_OUT, SRC_OUT, VLD_OUT, ptr and cnt all hold. No packet is lost or duplicated.
- Throughput: 1 packet/cycle while RDY_IN=1 and any input is eligible. Latency is 1 cycle from input acceptance to VLD_OUT.
- Burst owner goes idle mid-burst: the search moves on to the next eligible input, and that input's burst starts with new=1.
- Owner returns after an interruption: its count restarts from 1; credit is not remembered.
- WEIGHT changed mid-burst: the >= compare ends the burst at the next transfer if the count already exceeds the new weight. A weight changed to 0 masks the input immediately.
- Single eligible input: it is granted every cycle at full throughput regardless of its weight, because the pointer wraps back to it.
- cnt never exceeds 2^WEIGHT_BITS-1. new is computed at WEIGHT_BITS+1 bits so it cannot overflow.
- Reset asserted mid-operation: any packet held in the output register is discarded (VLD_OUT=0 after the edge). Upstream sees no handshake during the reset cycle.

Decomposition:
- Package spio_wrr_pkg:
  - NUM_PORTS=4, PORT_BITS=2.
  - Weight/count type of width WEIGHT_BITS.
  - Reset constants for ptr and cnt.
- Sub-module spio_wrr_grant (combinational):
  - Inputs: 4-bit eligible vector, ptr.
  - Outputs: grant_valid and g, from a rotate / priority-encode / unrotate search.
- The top level holds the output register, ptr/cnt update and RDY generation.

Test Plan:
- Weights (1,1,1,1), all valid, RDY_IN=1 → SRC_OUT sequence 0,1,2,3,0,1,… and one packet per cycle.
- Weights (3,1,2,1), all valid → SRC_OUT 0,0,0,1,2,2,3 repeating; each input's sequence numbers are consecutive with none missing.
- Weights (2,2,2,2), all valid, RDY_IN low for 10 cycles mid-burst → DATA_OUT/SRC_OUT frozen and all RDYn_OUT=0; after release the sequence resumes with no loss or duplicate.
- Only input 2 valid, weight 1 → forwarded every cycle. Raise VLD0 → alternates 0,2,0,2 (ptr wraps past 3).
- WEIGHT1_IN=0 with all valid → input 1 is never granted and RDY1_OUT stays 0. Set WEIGHT1_IN=1 → input 1 is granted within 4 transfers.
- Assert RESET_IN for 1 cycle while VLD_OUT=1 and RDY_IN=0 → next cycle VLD_OUT=0, ptr=0, cnt=0, and no RDY was asserted during reset. The first grant after reset goes to the lowest-index eligible input.
